a0_uart_tx: RTL
===============

Name: a0_uart_tx

Overview:
- Observer/transmitter on the a0 output of the CPU register file: the consumer end of the register file's a0 debug tap.
- Watches a0 every cycle. When its value differs from the last value sent, captures it and serialises it LSB-byte-first as 8N1 UART frames on tx_o.
- Sits at the top level between the core and the board's UART pin, and gives software a "print a0" channel with no bus interface.

Parameters:
- DATA_WIDTH, 32, width of a0; must be a multiple of 8; BYTES = DATA_WIDTH/8.
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); must be >= 2.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- a0_i  input  DATA_WIDTH  live a0 value from the register file.
- en_i  input  1  transmit enable; when low, no new capture starts (a frame in flight completes).
- tx_o  output  1  UART serial line, idle high.
- busy_o  output  1  high from the capture cycle until the final stop bit ends.
- sent_o  output  1  one-cycle pulse when the last stop bit of a word completes.
- overrun_o  output  1  sticky; set when a0 changes two or more times during one transmission.

Behaviour:
- Reset (async assert, sync release): tx_o=1, busy_o=0, sent_o=0, overrun_o=0, state=IDLE, last_sent=0, a0_prev=0, all counters 0.
- Consequence of last_sent=0: a0 holding 0 after reset sends nothing.
- States: IDLE, START, DATA, STOP.
- IDLE:
  - Capture when en_i=1 and a0_i != last_sent on rising edge N.
  - On capture: shift register <= a0_i, last_sent <= a0_i, byte_cnt <= 0, state <= START.
  - From cycle N+1: busy_o=1 and tx_o=0.
- START: tx_o=0 for CLKS_PER_BIT cycles, then DATA with bit_cnt=0.
- DATA:
  - tx_o = shift[0] for CLKS_PER_BIT cycles per bit.
  - At each bit end: shift right one bit, bit_cnt++.
  - After 8 bits, go to STOP.
- STOP: tx_o=1 for CLKS_PER_BIT cycles, then:
  - if byte_cnt < BYTES-1: byte_cnt++, go to START. No idle gap between bytes.
  - else: go to IDLE; sent_o=1 and busy_o=0 in the first IDLE cycle.
- Timing:
  - Word duration = BYTES*10*CLKS_PER_BIT cycles.
  - Baud counter counts 0..CLKS_PER_BIT-1 and resets on every state or bit change.
- Re-arm: in the first IDLE cycle after a word, a0_i is compared again. If a0_i != last_sent and en_i=1, capture happens that same cycle.
  - Result: the latest a0 value is always eventually sent; intermediate values seen during busy are lost.
  - In that back-to-back case sent_o still pulses and busy_o stays 1 (a new capture happens the same cycle).
- Overrun detection:
  - a0_prev <= a0_i every cycle; a change event is a0_i != a0_prev.
  - Change events are counted (saturating at 2) while busy_o=1; the count clears at each capture.
  - overrun_o is set when the count reaches 2.
  - overrun_o clears only on reset.
- en_i deasserted mid-word: no effect on the current word; the next capture is blocked until en_i=1.
- Reset mid-frame: tx_o returns high immediately (asynchronous), the frame is truncated, and no sent_o is produced.
- Byte order: byte 0 = a0[7:0] first; within each byte, LSB first.
- Sampling a0 on posedge while the register file writes on negedge is intentional: a0 is stable at each rising edge.

Test Plan:
- Reset, a0_i=0, en_i=1, 200 cycles (CLKS_PER_BIT=4) -> tx_o stays 1, busy_o=0, no sent_o.
- a0_i=32'h0000_0041, CLKS_PER_BIT=4 -> tx_o=0 starting the cycle after capture. Decoded stream is bytes 41,00,00,00, each 0, data LSB-first, 1. busy_o high for 160 cycles, then one sent_o pulse.
- a0_i=32'hDEAD_BEEF held -> exactly one word sent (EF,BE,AD,DE); no retransmission afterwards.
- During a transmission of 1, a0_i goes 2 then 3 -> overrun_o=1. The next word sent is 3, starting the same cycle sent_o pulses, with busy_o staying 1.
- en_i=0 with a0_i=5 -> nothing sent. Raising en_i -> word 05,00,00,00 sent.
- Assert rst_n=0 during the DATA state of byte 1 -> tx_o=1 and busy_o=0 immediately. After release with a0_i=5, the full word is resent (last_sent=0).

Source files
------------

// File: rtl/a0_uart_tx.sv
// Watches the register-file a0 tap and transmits each new value as BYTES 8N1 frames,
// LSB byte first, on tx_o. Values that change while a word is in flight are dropped; only the latest is sent.
module a0_uart_tx #(
  parameter int DATA_WIDTH   = 32,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] a0_i,
  input  logic                  en_i,
  output logic                  tx_o,
  output logic                  busy_o,
  output logic                  sent_o,
  output logic                  overrun_o
);
  localparam int BYTES  = DATA_WIDTH / 8;
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BYTE_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(BYTES - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic [DATA_WIDTH-1:0]   last_sent_q, last_sent_d;
  logic [DATA_WIDTH-1:0]   a0_prev_q, a0_prev_d;
  logic [BAUD_W-1:0]       baud_q, baud_d;
  logic [2:0]              bit_q, bit_d;
  logic [BYTE_W-1:0]       byte_q, byte_d;
  logic [1:0]              chg_q, chg_d;
  logic                    tx_q, tx_d;
  logic                    busy_q, busy_d;
  logic                    sent_q, sent_d;
  logic                    overrun_q, overrun_d;
  logic                    capture_ok, baud_end, capture;

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    last_sent_d = last_sent_q;
    a0_prev_d   = a0_i;
    baud_d      = baud_q;
    bit_d       = bit_q;
    byte_d      = byte_q;
    chg_d       = chg_q;
    tx_d        = tx_q;
    busy_d      = busy_q;
    sent_d      = 1'b0;
    capture_ok  = en_i && (a0_i != last_sent_q);
    baud_end    = (baud_q == BAUD_LAST);
    capture     = 1'b0;

    case (state_q)
      IDLE: capture = capture_ok;
      START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          state_d = DATA;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            tx_d = shift_q[1];
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (byte_q != BYTE_LAST) begin
            // After eight shifts the next byte already sits in the low bits.
            byte_d  = byte_q + BYTE_W'(1);
            state_d = START;
            tx_d    = 1'b0;
          end else begin
            sent_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
            tx_d    = 1'b1;
            capture = capture_ok;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // A capture here overrides the word-end decision so busy_o never drops between words.
    if (capture) begin
      shift_d     = a0_i;
      last_sent_d = a0_i;
      byte_d      = '0;
      bit_d       = 3'd0;
      baud_d      = '0;
      state_d     = START;
      tx_d        = 1'b0;
      busy_d      = 1'b1;
      chg_d       = 2'd0;
    end else if (busy_q && (a0_i != a0_prev_q) && (chg_q != 2'd2)) begin
      chg_d = chg_q + 2'd1;
    end
    overrun_d = overrun_q | (chg_d == 2'd2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      last_sent_q <= '0;
      a0_prev_q   <= '0;
      baud_q      <= '0;
      bit_q       <= 3'd0;
      byte_q      <= '0;
      chg_q       <= 2'd0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      sent_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      last_sent_q <= last_sent_d;
      a0_prev_q   <= a0_prev_d;
      baud_q      <= baud_d;
      bit_q       <= bit_d;
      byte_q      <= byte_d;
      chg_q       <= chg_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
      sent_q      <= sent_d;
      overrun_q   <= overrun_d;
    end
  end

  assign tx_o      = tx_q;
  assign busy_o    = busy_q;
  assign sent_o    = sent_q;
  assign overrun_o = overrun_q;
endmodule
